// File: rtl/raizing_rom_arbiter.sv
// Per-channel one-line ROM cache with a single SDRAM port: 3-cycle minimum miss-to-OK, hits are combinational.
// Backpressure: BA_RD/BA_ADDR hold until BA_ACK; a fill completes only on BA_RDY; DOWNLOADING stalls new grants.
module raizing_rom_arbiter #(
  parameter int NCH       = 4,
  parameter int AW        = 22,
  parameter int PRIO_MODE = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DOWNLOADING,
  input  logic              INVALIDATE,
  input  logic [NCH-1:0]    CS,
  input  logic [NCH*AW-1:0] ADDR,
  output logic [NCH-1:0]    OK,
  output logic [NCH*16-1:0] DOUT,
  output logic [AW-1:0]     BA_ADDR,
  output logic              BA_RD,
  input  logic              BA_ACK,
  input  logic              BA_RDY,
  input  logic [15:0]       DATA_READ
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   gnt, gnt_nxt;
  logic [IW-1:0]   last_grant, last_grant_nxt;
  logic            ba_rd_nxt;
  logic [AW-1:0]   ba_addr_nxt;
  logic            inv_seen, inv_seen_nxt;
  logic            load;

  logic            valid [NCH];
  logic [AW-1:0]   tag   [NCH];
  logic [15:0]     data  [NCH];

  logic [NCH-1:0]  pending;
  logic            found;
  logic [IW-1:0]   pick;
  logic [AW-1:0]   pick_addr;
  int              idx;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign OK[gi]              = CS[gi] & valid[gi] & (tag[gi] == ADDR[gi*AW +: AW]);
    assign DOUT[gi*16 +: 16]   = data[gi];
    assign pending[gi]         = CS[gi] & ~OK[gi] & ~((state != IDLE) && (gnt == IW'(gi)));
  end

  // Round-robin starts one past the last winner; fixed priority always starts at 0.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_addr = '0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (PRIO_MODE == 1) ? ((int'(last_grant) + 1 + k) % NCH) : k;
      if (!found && pending[idx]) begin
        found     = 1'b1;
        pick      = IW'(idx);
        pick_addr = ADDR[idx*AW +: AW];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    last_grant_nxt = last_grant;
    ba_rd_nxt      = BA_RD;
    ba_addr_nxt    = BA_ADDR;
    inv_seen_nxt   = inv_seen | INVALIDATE;
    load           = 1'b0;
    case (state)
      IDLE: begin
        if (!DOWNLOADING && found) begin
          state_nxt      = WAIT_ACK;
          gnt_nxt        = pick;
          last_grant_nxt = pick;
          ba_rd_nxt      = 1'b1;
          ba_addr_nxt    = pick_addr;
          inv_seen_nxt   = INVALIDATE;
        end
      end
      WAIT_ACK: begin
        if (BA_ACK) begin
          ba_rd_nxt = 1'b0;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (BA_RDY) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      gnt        <= '0;
      last_grant <= IW'(NCH - 1);
      BA_RD      <= 1'b0;
      BA_ADDR    <= '0;
      inv_seen   <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_grant <= last_grant_nxt;
      BA_RD      <= ba_rd_nxt;
      BA_ADDR    <= ba_addr_nxt;
      inv_seen   <= inv_seen_nxt;
    end
  end

  // The fill write follows the invalidate sweep so it wins for the served line.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= '0;
        data[i]  <= '0;
      end
    end else begin
      if (INVALIDATE) begin
        for (int i = 0; i < NCH; i++) valid[i] <= 1'b0;
      end
      if (load) begin
        data[gnt]  <= DATA_READ;
        tag[gnt]   <= BA_ADDR;
        valid[gnt] <= ~(inv_seen | INVALIDATE);
      end
    end
  end

endmodule

// File: doc/raizing_rom_arbiter.md
RAIZING_ROM_ARBITER -- requirements
Module: raizing_rom_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of ROM client channels, range 1..8.
REQ-002 Parameter AW, default 22: SDRAM word-address width.
REQ-003 Parameter PRIO_MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-004 Port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port RESET, input, 1: asynchronous, active-high reset.
REQ-006 Port DOWNLOADING, input, 1: ROM load in progress; blocks new SDRAM requests.
REQ-007 Port INVALIDATE, input, 1: clears all channel caches.
REQ-008 Port CS, input, NCH: per-channel read request.
REQ-009 Port ADDR, input, NCH*AW: per-channel word address; channel i occupies bits [i*AW +: AW].
REQ-010 Port OK, output, NCH: per-channel data valid for the current ADDR.
REQ-011 Port DOUT, output, NCH*16: per-channel read data; channel i occupies bits [i*16 +: 16].
REQ-012 Port BA_ADDR, output, AW: SDRAM bank address.
REQ-013 Port BA_RD, output, 1: SDRAM read request.
REQ-014 Port BA_ACK, input, 1: SDRAM accepted the request.
REQ-015 Port BA_RDY, input, 1: read data valid on DATA_READ.
REQ-016 Port DATA_READ, input, 16: SDRAM read data.

Function
REQ-017 Each channel SHALL hold one cache line: a valid flag, a tag (AW bits) and data (16 bits).
REQ-018 OK[i] SHALL be combinational and SHALL equal CS[i] & valid[i] & (tag[i] == ADDR[i]).
REQ-019 DOUT[i] SHALL equal data[i] at all times.
REQ-020 A channel is pending when CS[i] & ~OK[i] and it is not the channel currently being serviced.
REQ-021 The FSM SHALL have three states: IDLE, WAIT_ACK and WAIT_RDY.
REQ-022 IDLE: if DOWNLOADING=0 and any channel is pending, the FSM SHALL grant one channel, latch its index and ADDR into BA_ADDR, set BA_RD=1 and move to WAIT_ACK. BA_RD and BA_ADDR are registered, so they are visible in the cycle after the pending condition is sampled.
REQ-023 PRIO_MODE=0: the grant SHALL go to the lowest-index pending channel.
REQ-024 PRIO_MODE=1: the search SHALL start at last_grant+1, wrapping modulo NCH; last_grant SHALL update on each grant.
REQ-025 WAIT_ACK: BA_RD and BA_ADDR SHALL stay stable until BA_ACK=1 is sampled. On that edge BA_RD SHALL go to 0 and the FSM SHALL move to WAIT_RDY.
REQ-026 WAIT_RDY: on the edge where BA_RDY=1, the granted channel's data SHALL be loaded from DATA_READ, its tag from the latched BA_ADDR and its valid flag set to 1; the FSM SHALL return to IDLE.
REQ-027 Latency: OK rises in the cycle after BA_RDY. The minimum request-to-OK time is 3 cycles, reached when BA_ACK and BA_RDY each arrive in the first cycle they can.
REQ-028 ADDR change during a transaction: the transaction SHALL complete with the old tag. OK stays low because of the tag mismatch, and the new address is requested from IDLE.
REQ-029 CS deasserted during a transaction: the transaction SHALL complete and its data SHALL be cached.
REQ-030 BA_ACK and BA_RDY high in the same cycle while in WAIT_ACK: only the ACK SHALL be taken; BA_RDY SHALL be honoured only in WAIT_RDY.
REQ-031 BA_ACK or BA_RDY while in IDLE SHALL be ignored.
REQ-032 INVALIDATE=1 SHALL clear every valid flag on that edge.
REQ-033 If INVALIDATE is asserted at any point between grant and BA_RDY, the in-flight result SHALL update tag and data but SHALL leave valid at 0.
REQ-034 INVALIDATE and a BA_RDY load on the same edge: the load's valid SHALL be 0.
REQ-035 DOWNLOADING=1 SHALL block new grants only; an in-flight transaction SHALL complete.

Reset
REQ-036 While RESET=1, asynchronously: FSM = IDLE, BA_RD = 0, BA_ADDR = 0, all valid = 0, all tags = 0, all data = 0, last_grant = NCH-1, and OK = 0.
REQ-037 Reset mid-transaction SHALL abandon the transaction. After release the arbiter SHALL restart from IDLE with no pending flags retained.

Verification
REQ-038 NCH=4, mode 0. CS=4'b0101, ADDR0=0x100, ADDR2=0x200, ACK/RDY one cycle after request.
 -> Channel 0 is served first (BA_ADDR=0x100), then channel 2. OK=4'b0101. Data matches the SDRAM model.
REQ-039 Mode 1. CS=4'b1111 held with changing addresses.
 -> Grants follow 0,1,2,3,0; no channel starves.
REQ-040 Channel 1 cached at 0x55. ADDR1 -> 0x56 while a channel 0 request is in flight.
 -> OK[1] drops combinationally. Channel 1 is requested next, with BA_ADDR=0x56.
REQ-041 INVALIDATE pulse between grant and BA_RDY.
 -> After BA_RDY, OK for the served channel stays 0 and the channel re-requests.
REQ-042 DOWNLOADING=1 with CS=4'b0001.
 -> BA_RD stays 0. After DOWNLOADING falls, BA_RD rises 1 cycle later.
REQ-043 RESET asserted in WAIT_RDY.
 -> BA_RD=0 and OK=0 immediately. After release the pending CS is re-requested from IDLE.
